// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-8 demultiplexing router.
package demux_pkg;

    localparam int unsigned NCH   = 8;
    localparam int unsigned SEL_W = 3;

    // Bit offset of channel k inside a flattened bus of w-bit lanes.
    function automatic int unsigned chan_slice(input int unsigned k, input int unsigned w = 1);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-word holding register with valid/ready and an accept counter.
module demux_slot #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free,
    output logic [CNT_W-1:0] cnt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A write wins over a drain, so a same-cycle drain and refill keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (wr) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (rd_ready & valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign cnt   = cnt_q;
    assign free  = ~valid_q | rd_ready;

endmodule

// File: rtl/demux8_router.sv
// Registered 1-to-8 demultiplexer with per-channel handshakes, accept counters and atomic broadcast.
module demux8_router
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH*CNT_W-1:0]   acc_cnt
);

    logic [NCH-1:0] free;
    logic [NCH-1:0] wr;
    logic           xfer;

    // Broadcast needs every channel free so it is never partially applied.
    always_comb begin
        in_ready = 1'b0;
        if (reset_n) begin
            in_ready = in_bcast ? (&free) : free[in_sel];
        end
        xfer = in_valid & in_ready;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam int unsigned DOFF = chan_slice(k, WIDTH);
        localparam int unsigned COFF = chan_slice(k, CNT_W);

        assign wr[k] = xfer & (in_bcast | (in_sel == SEL_W'(k)));

        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[DOFF +: WIDTH]),
            .free     (free[k]),
            .cnt      (acc_cnt[COFF +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux8_router.sv
// Directed and randomized checks of demux8_router against a per-channel array model.
module tb_demux8_router;
    import demux_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [2:0]           in_sel;
    logic                 in_bcast;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [8*WIDTH-1:0]   out_data;
    logic [8*CNT_W-1:0]   acc_cnt;

    demux8_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference state: what each channel should hold.
    bit          m_valid[8];
    int unsigned m_data[8];
    int unsigned m_cnt[8];

    function automatic int unsigned dut_data(input int unsigned k);
        return int'(out_data[chan_slice(k, WIDTH) +: WIDTH]);
    endfunction

    function automatic int unsigned dut_cnt(input int unsigned k);
        return int'(acc_cnt[chan_slice(k, CNT_W) +: CNT_W]);
    endfunction

    function automatic bit model_ready();
        bit all_free;
        if (!reset_n) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (m_valid[k] && !out_ready[k]) all_free = 1'b0;
        if (in_bcast) return all_free;
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("valid[%0d]", k), 64'(out_valid[k]), 64'(m_valid[k]));
            chk($sformatf("data[%0d]", k), 64'(dut_data(k)), 64'(m_data[k]));
            chk($sformatf("cnt[%0d]", k), 64'(dut_cnt(k)), 64'(m_cnt[k]));
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        bit r;
        #1;
        r = model_ready();
        chk("in_ready", 64'(in_ready), 64'(r));
        @(posedge clk);
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                m_valid[k] = 1'b0; m_data[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (in_valid && r && (in_bcast || int'(in_sel) == k)) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = int'(in_data);
                    m_cnt[k]   = (m_cnt[k] + 1) % (1 << CNT_W);
                end else if (out_ready[k] && m_valid[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    int unsigned sum_before, sum_after, saved_cnt0;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
        in_bcast = 1'b0; out_ready = '0;
        @(negedge clk);

        // 1: reset, then a single unicast to channel 3
        cycle(); cycle();
        reset_n = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_data = 4'hA;
        cycle();
        chk("t1_out_valid", 64'(out_valid), 64'h08);
        chk("t1_data3", 64'(dut_data(3)), 64'hA);
        chk("t1_cnt3", 64'(dut_cnt(3)), 64'd1);

        // 2: backpressure on the full channel, then same-edge drain and refill
        in_data = 4'h5;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_blocked_ready", 64'(in_ready), 64'd0);
            cycle();
            chk("t2_data3_held", 64'(dut_data(3)), 64'hA);
        end
        out_ready[3] = 1'b1;
        cycle();
        chk("t2_valid3", 64'(out_valid[3]), 64'd1);
        chk("t2_data3_new", 64'(dut_data(3)), 64'h5);
        chk("t2_cnt3", 64'(dut_cnt(3)), 64'd2);

        // 3: fill channel 6, block a broadcast on it, then release it
        out_ready = 8'h00; in_sel = 3'd6; in_data = 4'h1;
        cycle();
        out_ready = 8'hBF; in_bcast = 1'b1; in_data = 4'h7;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t3_bcast_blocked", 64'(in_ready), 64'd0);
            cycle();
            chk("t3_data6_held", 64'(dut_data(6)), 64'h1);
        end
        out_ready = 8'hFF;
        cycle();
        chk("t3_out_valid", 64'(out_valid), 64'hFF);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3_data[%0d]", k), 64'(dut_data(k)), 64'h7);

        // idle input with broadcast set must write nothing
        in_valid = 1'b0; in_data = 4'hE; out_ready = 8'h00;
        cycle();

        // 4: streaming with every consumer ready
        out_ready = 8'hFF; in_bcast = 1'b0; in_valid = 1'b1;
        sum_before = 0;
        for (int k = 0; k < 8; k++) sum_before += dut_cnt(k);
        for (int i = 0; i < 40; i++) begin
            in_sel  = 3'($urandom_range(0, 7));
            in_data = WIDTH'($urandom);
            #1 chk("t4_stream_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        sum_after = 0;
        for (int k = 0; k < 8; k++) sum_after += dut_cnt(k);
        chk("t4_count_sum", 64'(sum_after - sum_before), 64'd40);

        // random traffic: mixed valid, backpressure and occasional broadcasts
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_bcast  = 1'($urandom_range(0, 7) == 0);
            in_sel    = 3'($urandom);
            in_data   = WIDTH'($urandom);
            out_ready = 8'($urandom);
            cycle();
        end

        // 5: 256 writes to channel 0 wrap its counter back to where it started
        in_valid = 1'b1; in_bcast = 1'b0; in_sel = 3'd0; out_ready = 8'hFF;
        cycle();
        saved_cnt0 = m_cnt[0];
        for (int i = 0; i < 256; i++) begin
            in_data = WIDTH'($urandom);
            cycle();
        end
        chk("t5_cnt0_wrapped", 64'(dut_cnt(0)), 64'(saved_cnt0));

        // 6: reset while every channel is full
        in_bcast = 1'b1; in_data = 4'h9;
        cycle();
        out_ready = 8'h00;
        in_valid = 1'b0;
        cycle();
        chk("t6_all_full", 64'(out_valid), 64'hFF);
        reset_n = 1'b0; in_valid = 1'b1;
        #1 chk("t6_rst_ready", 64'(in_ready), 64'd0);
        cycle();
        chk("t6_out_valid", 64'(out_valid), 64'h00);
        chk("t6_out_data", 64'(out_data), 64'h0);
        chk("t6_acc_cnt", 64'(acc_cnt), 64'h0);
        cycle();
        reset_n = 1'b1; in_bcast = 1'b0; in_sel = 3'd5; in_data = 4'hC;
        cycle();
        chk("t6_first_after_rst", 64'(out_valid), 64'h20);
        chk("t6_cnt5", 64'(dut_cnt(5)), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
